note_judge: RTL and testbench

- Consumer end of the note-lane interface: watches the judge-column note flags and pixel offset from the note shifter, plus the player's red/blue buttons.
- Grades each note as PERFECT, GOOD or MISS, and returns a one-cycle delete pulse so the shifter clears a hit note.
- Keeps score, combo and max combo for the display/score block.

---
 rtl/note_judge_pkg.sv | 27 ++
 rtl/button_conditioner.sv | 50 +++++
 rtl/note_judge.sv | 168 ++++++++++++++++
 tb/tb_note_judge.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_judge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : note_judge_pkg
// Brief    : Shared types and constants for the note judge slice.
// Revision : 1.0 - initial release
// ============================================================================
package note_judge_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RESOLVED = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Colour codes match the shifter's note encoding
  localparam logic [1:0] C_COL_NONE = 2'd0;
  localparam logic [1:0] C_COL_RED  = 2'd1;
  localparam logic [1:0] C_COL_BLUE = 2'd2;

  localparam int C_PERFECT_PTS = 3;
  localparam int C_GOOD_PTS    = 1;

  localparam logic [2:0] C_OFFSET_WRAP = 3'd6;

endpackage
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : 2-FF synchronizer, counter debounce and one-cycle rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int C_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_level_d;
  logic [C_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
      press     <= 1'b0;
    end else begin
      r_sync1   <= raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      press     <= r_level & ~r_level_d;
      // Level flips only after an unbroken run of disagreeing samples
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + C_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/note_judge.sv
`default_nettype none
// ============================================================================
// Module   : note_judge
// Brief    : Grades judge-column notes against button presses; keeps score/combo.
// Revision : 1.0 - initial release
// ============================================================================
module note_judge
  import note_judge_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter logic [2:0] PERFECT_LO      = 3'd2,
  parameter logic [2:0] PERFECT_HI      = 3'd4,
  parameter int         SCORE_W         = 16,
  parameter int         PERFECT_PTS     = C_PERFECT_PTS,
  parameter int         GOOD_PTS        = C_GOOD_PTS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               note_R_judge,
  input  logic               note_B_judge,
  input  logic [2:0]         offset,
  input  logic               finish,
  input  logic               red_button,
  input  logic               blue_button,
  output logic               delete,
  output logic               hit_perfect,
  output logic               hit_good,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [7:0]         max_combo
);

  logic w_red_press;
  logic w_blue_press;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_red_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (red_button),
    .press (w_red_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_blue_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (blue_button),
    .press (w_blue_press)
  );

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_colour;
  logic [1:0]         w_colour_nxt;
  logic [2:0]         r_prev_offset;
  logic               w_boundary;
  logic               w_hit;
  logic               w_perfect;
  logic               w_del_nxt;
  logic               w_perf_nxt;
  logic               w_good_nxt;
  logic               w_miss_nxt;
  logic               w_combo_inc;
  logic               w_combo_clr;
  logic               w_clear_all;
  logic               w_freeze;
  logic [SCORE_W-1:0] w_points;
  logic [SCORE_W:0]   w_score_sum;

  assign w_boundary = (r_prev_offset == C_OFFSET_WRAP) && (offset == 3'd0);
  assign w_perfect  = (offset >= PERFECT_LO) && (offset <= PERFECT_HI);
  assign w_hit      = ((r_colour == C_COL_RED)  &&  w_red_press && !w_blue_press) ||
                      ((r_colour == C_COL_BLUE) && !w_red_press &&  w_blue_press);
  assign w_freeze   = finish || (r_state == ST_DONE);
  assign w_score_sum = {1'b0, score} + {1'b0, w_points};

  always_comb begin
    w_state_nxt  = r_state;
    w_colour_nxt = r_colour;
    w_del_nxt    = 1'b0;
    w_perf_nxt   = 1'b0;
    w_good_nxt   = 1'b0;
    w_miss_nxt   = 1'b0;
    w_combo_inc  = 1'b0;
    w_combo_clr  = 1'b0;
    w_clear_all  = 1'b0;
    w_points     = '0;
    if (finish) begin
      w_state_nxt = ST_DONE;
    end else begin
      // A boundary always takes precedence over a press in the same cycle
      if (r_state != ST_DONE && w_boundary) begin
        if (r_state == ST_ARMED) begin
          w_miss_nxt  = 1'b1;
          w_combo_clr = 1'b1;
        end
        if (note_R_judge || note_B_judge) begin
          w_state_nxt  = ST_ARMED;
          w_colour_nxt = note_R_judge ? C_COL_RED : C_COL_BLUE;
        end else begin
          w_state_nxt  = ST_EMPTY;
          w_colour_nxt = C_COL_NONE;
        end
      end else if (r_state == ST_ARMED) begin
        if (w_hit) begin
          w_del_nxt   = 1'b1;
          w_combo_inc = 1'b1;
          w_state_nxt = ST_RESOLVED;
          if (w_perfect) begin
            w_perf_nxt = 1'b1;
            w_points   = SCORE_W'(PERFECT_PTS);
          end else begin
            w_good_nxt = 1'b1;
            w_points   = SCORE_W'(GOOD_PTS);
          end
        end else if (w_red_press || w_blue_press) begin
          w_miss_nxt  = 1'b1;
          w_combo_clr = 1'b1;
          w_state_nxt = ST_RESOLVED;
        end
      end else if (r_state == ST_DONE) begin
        w_clear_all  = 1'b1;
        w_state_nxt  = ST_EMPTY;
        w_colour_nxt = C_COL_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_EMPTY;
      r_colour      <= C_COL_NONE;
      r_prev_offset <= 3'd0;
      delete        <= 1'b0;
      hit_perfect   <= 1'b0;
      hit_good      <= 1'b0;
      miss          <= 1'b0;
      score         <= '0;
      combo         <= 8'd0;
      max_combo     <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_colour      <= w_colour_nxt;
      r_prev_offset <= offset;
      delete        <= w_del_nxt;
      hit_perfect   <= w_perf_nxt;
      hit_good      <= w_good_nxt;
      miss          <= w_miss_nxt;
      if (w_clear_all) begin
        score     <= '0;
        combo     <= 8'd0;
        max_combo <= 8'd0;
      end else begin
        score <= w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
        if (w_combo_clr) begin
          combo <= 8'd0;
        end else if (w_combo_inc && combo != 8'hFF) begin
          combo <= combo + 8'd1;
        end
        if (!w_freeze && combo > max_combo) begin
          max_combo <= combo;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_note_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_judge
// Brief    : Scoreboard bench for note_judge: graded events queued at stimulus time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_judge;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        note_R_judge = 1'b0;
  logic        note_B_judge = 1'b0;
  logic [2:0]  offset = 3'd0;
  logic        finish = 1'b0;
  logic        red_button = 1'b0;
  logic        blue_button = 1'b0;
  logic        delete;
  logic        hit_perfect;
  logic        hit_good;
  logic        miss;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;

  int n_total = 0;
  int n_bad   = 0;
  int press_cnt = 0;
  int m_score = 0;
  int m_combo = 0;

  typedef struct {
    logic [3:0] flags;   // {delete, hit_perfect, hit_good, miss}
    int         score;
    int         combo;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  note_judge #(.DEBOUNCE_CYCLES(D)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .note_R_judge (note_R_judge),
    .note_B_judge (note_B_judge),
    .offset       (offset),
    .finish       (finish),
    .red_button   (red_button),
    .blue_button  (blue_button),
    .delete       (delete),
    .hit_perfect  (hit_perfect),
    .hit_good     (hit_good),
    .miss         (miss),
    .score        (score),
    .combo        (combo),
    .max_combo    (max_combo)
  );

  always @(negedge clk) if (u_dut.u_red_btn.press) press_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shifter wraps 6 -> 0 and presents the new judge column
  task automatic set_boundary(input logic r, input logic b);
    offset = 3'd6;
    cyc(1);
    offset = 3'd0;
    note_R_judge = r;
    note_B_judge = b;
    cyc(1);
    note_R_judge = 1'b0;
    note_B_judge = 1'b0;
  endtask

  task automatic push_button(input logic r, input logic b);
    red_button  = r;
    blue_button = b;
    cyc(D + 5);
    red_button  = 1'b0;
    blue_button = 1'b0;
    cyc(D + 5);
  endtask

  task automatic expect_event(input logic [3:0] flags);
    ev_t e;
    e.flags = flags;
    e.score = m_score;
    e.combo = m_combo;
    exp_q.push_back(e);
  endtask

  task automatic expect_hit(input logic [2:0] off);
    int pts;
    pts = (off >= 3'd2 && off <= 3'd4) ? 3 : 1;
    m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
    m_combo = (m_combo == 255) ? 255 : m_combo + 1;
    expect_event((pts == 3) ? 4'b1100 : 4'b1010);
  endtask

  task automatic note_hit(input logic red, input logic [2:0] off);
    set_boundary(red, ~red);
    offset = off;
    expect_hit(off);
    push_button(red, ~red);
  endtask

  initial begin
    int p0;
    int k;
    fork
      forever begin
        ev_t e;
        @(negedge clk);
        if (rst && (delete || hit_perfect || hit_good || miss)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", {28'd0, delete, hit_perfect, hit_good, miss}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("ev_flags", {28'd0, delete, hit_perfect, hit_good, miss}, {28'd0, e.flags});
            chk("ev_score", {16'd0, score}, e.score);
            chk("ev_combo", {24'd0, combo}, e.combo);
          end
        end
      end
    join_none

    cyc(3);
    chk("rst_pulses", {28'd0, delete, hit_perfect, hit_good, miss}, 32'd0);
    chk("rst_score", {16'd0, score}, 32'd0);
    chk("rst_combo", {24'd0, combo}, 32'd0);
    chk("rst_max", {24'd0, max_combo}, 32'd0);
    rst = 1'b1;
    cyc(2);

    note_hit(1'b1, 3'd3);
    chk("max_first", {24'd0, max_combo}, 32'd1);
    note_hit(1'b0, 3'd5);
    note_hit(1'b1, 3'd2);
    note_hit(1'b0, 3'd4);
    chk("score_four", {16'd0, score}, 32'd10);
    chk("max_four", {24'd0, max_combo}, 32'd4);

    // Unhit red note: miss at the next wrap, max_combo keeps 4
    set_boundary(1'b1, 1'b0);
    offset = 3'd3;
    cyc(10);
    m_combo = 0;
    expect_event(4'b0001);
    set_boundary(1'b0, 1'b0);
    cyc(2);
    chk("combo_after_miss", {24'd0, combo}, 32'd0);
    chk("max_after_miss", {24'd0, max_combo}, 32'd4);
    push_button(1'b1, 1'b0);

    // Both buttons together on a blue note, then a late blue press is ignored
    set_boundary(1'b0, 1'b1);
    offset = 3'd3;
    m_combo = 0;
    expect_event(4'b0001);
    push_button(1'b1, 1'b1);
    push_button(1'b0, 1'b1);
    chk("score_after_ignored", {16'd0, score}, m_score);

    // Bounce shorter than the debounce window, then a clean high level
    set_boundary(1'b1, 1'b0);
    offset = 3'd3;
    expect_hit(3'd3);
    p0 = press_cnt;
    for (int t = 0; t < 21; t++) begin
      red_button = ~red_button;
      if (t < 20) cyc(7);
    end
    k = 0;
    while (k < 60 && !delete) begin
      cyc(1);
      k++;
    end
    chk("bounce_latency", k, D + 4);
    cyc(D);
    red_button = 1'b0;
    cyc(D + 5);
    chk("bounce_press_count", press_cnt - p0, 32'd1);

    for (int i = 0; i < 199; i++) note_hit(1'b1, 3'(1 + (i % 6)));
    chk("combo_200", {24'd0, combo}, 32'd200);
    chk("max_200", {24'd0, max_combo}, 32'd200);
    chk("score_200", {16'd0, score}, m_score);

    // Song end: everything frozen until finish drops, then cleared
    p0 = m_score;
    finish = 1'b1;
    cyc(2);
    push_button(1'b1, 1'b0);
    set_boundary(1'b1, 1'b0);
    offset = 3'd3;
    push_button(1'b1, 1'b0);
    chk("done_score", {16'd0, score}, p0);
    chk("done_combo", {24'd0, combo}, 32'd200);
    chk("done_max", {24'd0, max_combo}, 32'd200);
    finish = 1'b0;
    cyc(1);
    chk("clr_score", {16'd0, score}, 32'd0);
    chk("clr_combo", {24'd0, combo}, 32'd0);
    chk("clr_max", {24'd0, max_combo}, 32'd0);
    m_score = 0;
    m_combo = 0;
    push_button(1'b1, 1'b0);

    for (int i = 0; i < 256; i++) note_hit(1'b1, 3'd3);
    chk("combo_sat", {24'd0, combo}, 32'd255);
    chk("max_sat", {24'd0, max_combo}, 32'd255);
    chk("score_768", {16'd0, score}, 32'd768);

    // Reset while a press pulse is about to register a delete
    set_boundary(1'b1, 1'b0);
    offset = 3'd3;
    red_button = 1'b1;
    cyc(D + 3);
    rst = 1'b0;
    cyc(1);
    chk("midrst_pulses", {28'd0, delete, hit_perfect, hit_good, miss}, 32'd0);
    chk("midrst_score", {16'd0, score}, 32'd0);
    chk("midrst_combo", {24'd0, combo}, 32'd0);
    chk("midrst_max", {24'd0, max_combo}, 32'd0);
    red_button = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(D + 6);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
